// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR write-back path.
//   XLEN       : data width of a register
//   REG_IDX_W  : width of a register index
//   NREG       : number of architectural registers
//   wb_req_t   : one write-back request {rd, data}
//   arb_state_e: write-port arbiter state
package gpr_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    typedef enum logic {
        LSU_PRI  = 1'b0,
        ALU_SLOT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of write-back requests, used to buffer LSU results.
//   clk, rstn_h : clock, synchronous active-low reset (empties the FIFO)
//   push        : write push_data (caller guarantees !full)
//   push_data   : request to enqueue
//   pop         : drop the head entry (caller guarantees !empty)
//   head        : oldest entry, valid while !empty
//   full, empty : occupancy flags derived from the entry count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo
    import gpr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rstn_h,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn_h) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/gpr_wb_ctrl.sv
// Write-side initiator for the general-purpose register file.
// Buffers LSU results, arbitrates between ALU and LSU for the single GPR
// write port, keeps a per-register busy scoreboard for issue stalls and
// produces bypass flags for the GPR's registered read data.
//   clk, rstn_h              : clock, synchronous active-low reset
//   alu_valid/ready/rd/data  : ALU result source
//   lsu_valid/ready/rd/data  : LSU result source (into a LSU_DEPTH buffer)
//   iss_valid, iss_rd        : issued instruction destination (marks busy)
//   rs1n, rs2n               : source indices presented to the GPR
//   stall                    : combinational, a source register is busy
//   rdn, rdd, wbe            : registered GPR write port
//   rs1_fwd, rs2_fwd         : registered, GPR read data is stale
//   fwd_data                 : registered copy of rdd from the forwarding edge
//   arb_state                : debug view of the arbiter state (1 = ALU_SLOT)
// Handshake: a result transfers on a cycle where valid && ready; a source
// holds rd/data stable while valid && !ready. ready may depend on valid.
module gpr_wb_ctrl
    import gpr_pkg::*;
#(
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rstn_h,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1n,
    input  logic [4:0]      rs2n,
    output logic            stall,
    output logic [4:0]      rdn,
    output logic [XLEN-1:0] rdd,
    output logic            wbe,
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] fwd_data,
    output logic            arb_state
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             grant_alu, grant_lsu;
    logic             fifo_full, fifo_empty, fifo_push;
    wb_req_t          lsu_req, lsu_head, sel_req;
    logic [NREG-1:0]  busy_q, busy_d;

    assign lsu_req   = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && lsu_ready;
    assign alu_ready = grant_alu;
    assign arb_state = state_q;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rstn_h    (rstn_h),
        .push      (fifo_push),
        .push_data (lsu_req),
        .pop       (grant_lsu),
        .head      (lsu_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arbiter: buffered LSU results normally win; after STARVE_MAX
    // consecutive denials of a waiting ALU result the ALU gets one slot.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        case (state_q)
            LSU_PRI: begin
                if (!fifo_empty) begin
                    grant_lsu = 1'b1;
                    if (alu_valid) begin
                        starve_d = starve_q + CNT_W'(1);
                        if (starve_d == CNT_W'(STARVE_MAX)) state_d = ALU_SLOT;
                    end
                end else if (alu_valid) begin
                    grant_alu = 1'b1;
                    starve_d  = '0;
                end
            end
            ALU_SLOT: begin
                if (alu_valid)        grant_alu = 1'b1;
                else if (!fifo_empty) grant_lsu = 1'b1;
                starve_d = '0;
                state_d  = LSU_PRI;
            end
            default: begin
                state_d  = LSU_PRI;
                starve_d = '0;
            end
        endcase
    end

    assign sel_req = grant_alu ? '{rd: alu_rd, data: alu_data} : lsu_head;

    // Scoreboard: a write retiring rdn clears its bit, an issue to the same
    // register in that cycle sets it again (set wins). x0 is never busy.
    always_comb begin
        busy_d = busy_q;
        if (wbe) busy_d[rdn] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign stall = busy_q[rs1n] | busy_q[rs2n];

    always_ff @(posedge clk) begin
        if (!rstn_h) begin
            state_q  <= LSU_PRI;
            starve_q <= '0;
            wbe      <= 1'b0;
            rdn      <= '0;
            rdd      <= '0;
            rs1_fwd  <= 1'b0;
            rs2_fwd  <= 1'b0;
            fwd_data <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            // Results to x0 are consumed but never reach the write port.
            wbe <= (grant_alu || grant_lsu) && (sel_req.rd != 5'd0);
            if ((grant_alu || grant_lsu) && (sel_req.rd != 5'd0)) begin
                rdn <= sel_req.rd;
                rdd <= sel_req.data;
            end
            // The GPR reads the old value on the edge that writes rdn.
            rs1_fwd  <= wbe && (rdn != 5'd0) && (rdn == rs1n);
            rs2_fwd  <= wbe && (rdn != 5'd0) && (rdn == rs2n);
            fwd_data <= rdd;
        end
    end
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
module tb_gpr_wb_ctrl;
    logic        clk = 1'b0;
    logic        rstn_h;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1n, rs2n, rdn;
    logic [31:0] alu_data, lsu_data, rdd, fwd_data;
    logic        iss_valid, stall, wbe, rs1_fwd, rs2_fwd, arb_state;

    int checks = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [36:0] obs_q[$];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_wbe;
        logic        e_f1;
        logic        e_f2;
    } vec_t;
    vec_t vecs[5];

    gpr_wb_ctrl dut (
        .clk(clk), .rstn_h(rstn_h),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1n(rs1n), .rs2n(rs2n),
        .stall(stall), .rdn(rdn), .rdd(rdd), .wbe(wbe),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data), .arb_state(arb_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write-port monitor
    always @(negedge clk) begin
        if (rstn_h && wbe) obs_q.push_back({rdn, rdd});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1; alu_rd = rd; alu_data = data;
        #1;
        chk("alu_ready_accept", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
    endtask

    initial begin
        int lsu_idx, alu_pending, alu_acc, blk_cnt, first_blk, cyc, stall_cnt;
        logic lf, af;

        vecs[0] = '{5'd3,  32'h0000_DEAD, 5'd3,  5'd4,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{5'd4,  32'h0000_1234, 5'd1,  5'd4,  1'b1, 1'b0, 1'b1};
        vecs[2] = '{5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{5'd0,  32'h0000_00FF, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd10, 32'h0000_A5A5, 5'd11, 5'd9,  1'b1, 1'b0, 1'b0};

        // reset state
        idle_inputs();
        rs1n = '0; rs2n = '0;
        rstn_h = 1'b0;
        tick(); tick();
        chk("rst_wbe", wbe, 1'b0);
        chk("rst_rdn", rdn, 5'd0);
        chk("rst_rdd", rdd, 32'd0);
        chk("rst_fwd", {rs1_fwd, rs2_fwd}, 2'b00);
        chk("rst_fwd_data", fwd_data, 32'd0);
        chk("rst_lsu_ready", lsu_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_arb_state", arb_state, 1'b0);
        rstn_h = 1'b1;
        tick();

        // table-driven ALU writes with forwarding
        for (int i = 0; i < 5; i++) begin
            rs1n = vecs[i].rs1; rs2n = vecs[i].rs2;
            alu_write(vecs[i].rd, vecs[i].data);
            chk("vec_wbe", wbe, vecs[i].e_wbe);
            if (vecs[i].e_wbe) begin
                chk("vec_rdn", rdn, vecs[i].rd);
                chk("vec_rdd", rdd, vecs[i].data);
            end
            tick();
            chk("vec_rs1_fwd", rs1_fwd, vecs[i].e_f1);
            chk("vec_rs2_fwd", rs2_fwd, vecs[i].e_f2);
            if (vecs[i].e_wbe) chk("vec_fwd_data", fwd_data, vecs[i].data);
            chk("vec_wbe_after", wbe, 1'b0);
        end

        // scoreboard set / clear
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        rs1n = 5'd7; rs2n = 5'd0;
        #1;
        chk("sb_stall_set", stall, 1'b1);
        alu_write(5'd7, 32'h11);
        chk("sb_wbe", wbe, 1'b1);
        chk("sb_rdn", rdn, 5'd7);
        chk("sb_rdd", rdd, 32'h11);
        chk("sb_stall_on_wbe", stall, 1'b1);
        tick();
        chk("sb_stall_clear", stall, 1'b0);

        // iss_rd = 0 never marks busy
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        rs1n = 5'd0; rs2n = 5'd0;
        #1;
        chk("sb_x0_stall", stall, 1'b0);

        // set wins over a same-cycle clear
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        iss_valid = 1'b0;
        alu_write(5'd8, 32'h88);
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        iss_valid = 1'b0;
        rs1n = 5'd8;
        #1;
        chk("sb_set_wins", stall, 1'b1);
        tick();
        chk("sb_set_wins_hold", stall, 1'b1);
        alu_write(5'd8, 32'h89);
        tick();
        chk("sb_set_wins_clear", stall, 1'b0);
        rs1n = 5'd0;

        // starvation, forced ALU slot and buffer full
        exp_q.delete();
        for (int k = 1; k <= 4; k++) exp_q.push_back({5'(k), 32'h100 + 32'(k)});
        exp_q.push_back({5'd9, 32'h900});
        for (int k = 5; k <= 8; k++) exp_q.push_back({5'(k), 32'h100 + 32'(k)});
        tick();
        obs_q.delete();
        lsu_idx = 0; alu_pending = 1; alu_acc = 0; blk_cnt = 0; first_blk = -1; cyc = 0;
        while (cyc < 40 && (lsu_idx < 8 || alu_pending != 0)) begin
            lsu_valid = (lsu_idx < 8);
            lsu_rd    = 5'(lsu_idx + 1);
            lsu_data  = 32'h100 + 32'(lsu_idx + 1);
            alu_valid = (alu_pending != 0) && (cyc >= 1);
            alu_rd    = 5'd9;
            alu_data  = 32'h900;
            #1;
            lf = lsu_valid && lsu_ready;
            af = alu_valid && alu_ready;
            if (lsu_valid && !lsu_ready) begin
                blk_cnt++;
                if (first_blk < 0) first_blk = lsu_idx;
            end
            if (af) alu_acc++;
            tick();
            if (lf) lsu_idx++;
            if (af) alu_pending = 0;
            cyc++;
        end
        idle_inputs();
        chk("stream_done", (lsu_idx == 8) && (alu_pending == 0), 1'b1);
        repeat (4) tick();
        chk("alu_accept_count", alu_acc, 1);
        chk("full_first_block_idx", first_blk, 6);
        chk("full_block_cycles", blk_cnt, 1);
        chk("write_count", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < obs_q.size()) chk("write_order", obs_q[k], exp_q[k]);
        end

        // reset in the middle of a write
        iss_valid = 1'b1; iss_rd = 5'd6;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5;
        tick();
        idle_inputs();
        chk("mid_wbe_before", wbe, 1'b1);
        rs1n = 5'd6; rs2n = 5'd0;
        #1;
        chk("mid_stall_before", stall, 1'b1);
        rs1n = 5'd5;
        rstn_h = 1'b0;
        tick();
        chk("mid_rst_wbe", wbe, 1'b0);
        chk("mid_rst_rdn", rdn, 5'd0);
        chk("mid_rst_rs1_fwd", rs1_fwd, 1'b0);
        chk("mid_rst_lsu_ready", lsu_ready, 1'b1);
        stall_cnt = 0;
        for (int r = 0; r < 32; r++) begin
            rs1n = 5'(r); rs2n = 5'(r);
            #1;
            if (stall) stall_cnt++;
        end
        chk("mid_rst_stall_all", stall_cnt, 0);
        rs1n = '0; rs2n = '0;
        rstn_h = 1'b1;
        tick();
        chk("mid_rst_no_write1", wbe, 1'b0);
        tick();
        chk("mid_rst_no_write2", wbe, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
